sram_bus_arbiter: RTL and testbench

- Sits directly upstream of the SRAM controller and is the only master of its bus.
- Accepts word requests from two CPU-side ports:
  - instruction fetch: read-only.
  - data memory: read/write with byte mask.
- Serialises the requests onto the controller's single-op interface and returns read data with a one-cycle ack.
- Drives per-port stall signals to the pipeline.

---
 rtl/sram_bus_arbiter_if.sv | 47 ++++
 rtl/sram_bus_arbiter.sv | 106 ++++++++++
 tb/tb_sram_bus_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_bus_arbiter_if.sv
// CPU-side fetch/data ports and SRAM controller single-op bus as seen by the arbiter.
// master = arbiter side, slave = pipeline + controller side.
interface sram_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 22,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = 4
);
  logic                  inst_req;
  logic [31:0]           inst_addr;
  logic [DATA_WIDTH-1:0] inst_rdata;
  logic                  inst_ack;
  logic                  inst_stall;

  logic                  data_req;
  logic                  data_we;
  logic [31:0]           data_addr;
  logic [DATA_WIDTH-1:0] data_wdata;
  logic [MASK_WIDTH-1:0] data_mask;
  logic [DATA_WIDTH-1:0] data_rdata;
  logic                  data_ack;
  logic                  data_stall;

  logic                  read_op;
  logic                  write_op;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_data_write;
  logic [MASK_WIDTH-1:0] byte_mask;
  logic [DATA_WIDTH-1:0] bus_data_read;

  modport master (
    input  inst_req, inst_addr,
    output inst_rdata, inst_ack, inst_stall,
    input  data_req, data_we, data_addr, data_wdata, data_mask,
    output data_rdata, data_ack, data_stall,
    output read_op, write_op, bus_addr, bus_data_write, byte_mask,
    input  bus_data_read
  );

  modport slave (
    output inst_req, inst_addr,
    input  inst_rdata, inst_ack, inst_stall,
    output data_req, data_we, data_addr, data_wdata, data_mask,
    input  data_rdata, data_ack, data_stall,
    input  read_op, write_op, bus_addr, bus_data_write, byte_mask,
    output bus_data_read
  );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Serialises fetch and data word requests onto the SRAM controller's single-op bus.
// Req in IDLE -> ack 3 cycles later, one access per 3 cycles; ports stall until their ack.
module sram_bus_arbiter #(
  parameter int ADDR_WIDTH = 22,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = 4
) (
  input logic                clk,
  input logic                rst,
  sram_bus_arbiter_if.master arb
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [MASK_WIDTH-1:0] mask_q, mask_d;
  logic                  we_q, we_d;
  logic                  grant_data_q, grant_data_d;
  logic                  last_was_data_q, last_was_data_d;

  logic cand_inst, cand_data, pick_data;

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    mask_d          = mask_q;
    we_d            = we_q;
    grant_data_d    = grant_data_q;
    last_was_data_d = last_was_data_q;
    cand_inst       = 1'b0;
    cand_data       = 1'b0;

    case (state_q)
      S_IDLE: begin
        cand_inst = arb.inst_req;
        cand_data = arb.data_req;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  state_d = S_RESP;
      S_RESP: begin
        state_d   = S_IDLE;
        // The port being acked this cycle is still holding req; it must not re-win.
        cand_inst = arb.inst_req & grant_data_q;
        cand_data = arb.data_req & ~grant_data_q;
      end
      default: state_d = S_IDLE;
    endcase

    pick_data = cand_data & (~cand_inst | ~last_was_data_q);

    if (cand_inst | cand_data) begin
      state_d         = S_ISSUE;
      grant_data_d    = pick_data;
      last_was_data_d = pick_data;
      if (pick_data) begin
        addr_d  = arb.data_addr[ADDR_WIDTH-1:0];
        wdata_d = arb.data_wdata;
        mask_d  = arb.data_mask;
        we_d    = arb.data_we;
      end else begin
        addr_d  = arb.inst_addr[ADDR_WIDTH-1:0];
        wdata_d = '0;
        mask_d  = '1;
        we_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      wdata_q         <= '0;
      mask_q          <= '0;
      we_q            <= 1'b0;
      grant_data_q    <= 1'b0;
      last_was_data_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      mask_q          <= mask_d;
      we_q            <= we_d;
      grant_data_q    <= grant_data_d;
      last_was_data_q <= last_was_data_d;
    end
  end

  assign arb.read_op        = (state_q == S_ISSUE) & ~we_q;
  assign arb.write_op       = (state_q == S_ISSUE) & we_q;
  assign arb.bus_addr       = addr_q;
  assign arb.bus_data_write = wdata_q;
  assign arb.byte_mask      = mask_q;

  assign arb.inst_ack   = (state_q == S_RESP) & ~grant_data_q;
  assign arb.data_ack   = (state_q == S_RESP) & grant_data_q;
  assign arb.inst_rdata = arb.inst_ack ? arb.bus_data_read : '0;
  assign arb.data_rdata = arb.data_ack ? arb.bus_data_read : '0;
  assign arb.inst_stall = arb.inst_req & ~arb.inst_ack;
  assign arb.data_stall = arb.data_req & ~arb.data_ack;
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: directed vector table, multi-cycle corner sequences,
// and randomized two-port traffic against a transaction-level reference model.
module tb_sram_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_clr;
  logic [31:0] seed;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_bus_arbiter_if #(.ADDR_WIDTH(22), .DATA_WIDTH(32), .MASK_WIDTH(4)) intf ();

  sram_bus_arbiter #(.ADDR_WIDTH(22), .DATA_WIDTH(32), .MASK_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .arb (intf.master)
  );

  // Initial memory contents: fixed words for directed tests, hashed words otherwise.
  function automatic logic [31:0] base_val(input logic [7:0] i, input logic [31:0] s);
    logic [31:0] r;
    if (s == 32'd0) begin
      case (i)
        8'd4:    r = 32'h2408_0001;
        8'd64:   r = 32'h55AA_55AA;
        8'd65:   r = 32'h1122_3344;
        8'd255:  r = 32'hCAFE_F00D;
        default: r = {4{i}};
      endcase
    end else begin
      r = ({4{i}} * 32'h9E37_79B1) ^ s;
    end
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] wd,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  // SRAM controller model: access one edge after the op, read word visible after the next.
  logic [31:0]  mem_q [0:255];
  logic [255:0] wr_q;
  logic         pend, pend_we;
  logic [7:0]   pend_idx;
  logic [31:0]  pend_wd;
  logic [3:0]   pend_m;

  always @(posedge clk) begin
    if (mem_clr) begin
      wr_q <= '0;
    end else if (pend && pend_we) begin
      mem_q[pend_idx] <= merge(wr_q[pend_idx] ? mem_q[pend_idx] : base_val(pend_idx, seed),
                               pend_wd, pend_m);
      wr_q[pend_idx]  <= 1'b1;
    end
    if (pend && !pend_we)
      intf.bus_data_read <= wr_q[pend_idx] ? mem_q[pend_idx] : base_val(pend_idx, seed);
    pend     <= intf.read_op | intf.write_op;
    pend_we  <= intf.write_op;
    pend_idx <= intf.bus_addr[9:2];
    pend_wd  <= intf.bus_data_write;
    pend_m   <= intf.byte_mask;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    intf.inst_req = 1'b0;
    intf.data_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        is_data;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [21:0] exp_addr;
    logic [3:0]  exp_mask;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [5];

  task automatic run_vec(input vec_t v, input int n);
    string tag;
    tag = $sformatf("vec%0d", n);
    if (v.is_data) begin
      intf.data_req = 1'b1;  intf.data_we = v.we;     intf.data_addr = v.addr;
      intf.data_wdata = v.wdata; intf.data_mask = v.mask;
    end else begin
      intf.inst_req = 1'b1;  intf.inst_addr = v.addr;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk({tag, " read_op"},  64'(intf.read_op),  64'(k == 1 && !v.we));
      chk({tag, " write_op"}, 64'(intf.write_op), 64'(k == 1 && v.we));
      chk({tag, " inst_ack"}, 64'(intf.inst_ack), 64'(k == 3 && !v.is_data));
      chk({tag, " data_ack"}, 64'(intf.data_ack), 64'(k == 3 && v.is_data));
      if (v.is_data) chk({tag, " data_stall"}, 64'(intf.data_stall), 64'(k < 3));
      else           chk({tag, " inst_stall"}, 64'(intf.inst_stall), 64'(k < 3));
      if (k >= 1) begin
        chk({tag, " bus_addr"},  64'(intf.bus_addr),  64'(v.exp_addr));
        chk({tag, " byte_mask"}, 64'(intf.byte_mask), 64'(v.exp_mask));
        if (v.we) chk({tag, " bus_wdata"}, 64'(intf.bus_data_write), 64'(v.wdata));
      end
      if (k == 3 && !v.we) begin
        if (v.is_data) chk({tag, " data_rdata"}, 64'(intf.data_rdata), 64'(v.exp_rdata));
        else           chk({tag, " inst_rdata"}, 64'(intf.inst_rdata), 64'(v.exp_rdata));
      end
      tick();
    end
    intf.inst_req = 1'b0;
    intf.data_req = 1'b0;
    tick();
  endtask

  // Reference model state for the random phase
  logic [31:0]  ref_mem [0:255];
  logic [255:0] ref_wr;
  logic         infl, g_data, g_we, lwd, acked, ci, cd, win;
  logic [31:0]  g_addr, g_wdata, cur;
  logic [3:0]   g_mask;
  logic [7:0]   idx;
  int           ack_c, next_free;
  logic         i_busy, d_busy, last_iack, last_dack;

  initial begin
    rst = 1'b1;
    mem_clr = 1'b1;
    seed = 32'd0;
    intf.inst_req = 1'b0;  intf.inst_addr = '0;
    intf.data_req = 1'b0;  intf.data_we = 1'b0;  intf.data_addr = '0;
    intf.data_wdata = '0;  intf.data_mask = '0;

    vecs[0] = '{is_data:1'b0, we:1'b0, addr:32'h8000_0010, wdata:32'h0, mask:4'h0,
                exp_addr:22'h00_0010, exp_mask:4'hF, exp_rdata:32'h2408_0001};
    vecs[1] = '{is_data:1'b1, we:1'b1, addr:32'h8000_0104, wdata:32'hDEAD_BEEF, mask:4'b0011,
                exp_addr:22'h00_0104, exp_mask:4'b0011, exp_rdata:32'h0};
    vecs[2] = '{is_data:1'b1, we:1'b0, addr:32'h0000_0104, wdata:32'h0, mask:4'hF,
                exp_addr:22'h00_0104, exp_mask:4'hF, exp_rdata:32'h1122_BEEF};
    vecs[3] = '{is_data:1'b0, we:1'b0, addr:32'hFFFF_FFFC, wdata:32'h0, mask:4'h0,
                exp_addr:22'h3F_FFFC, exp_mask:4'hF, exp_rdata:32'hCAFE_F00D};
    vecs[4] = '{is_data:1'b1, we:1'b0, addr:32'h0040_0100, wdata:32'h0, mask:4'b0101,
                exp_addr:22'h00_0100, exp_mask:4'b0101, exp_rdata:32'h55AA_55AA};

    tick();
    mem_clr = 1'b0;
    do_reset();
    @(negedge clk);
    chk("rst read_op",   64'(intf.read_op),        64'(0));
    chk("rst write_op",  64'(intf.write_op),       64'(0));
    chk("rst bus_addr",  64'(intf.bus_addr),       64'(0));
    chk("rst bus_wdata", 64'(intf.bus_data_write), 64'(0));
    chk("rst byte_mask", 64'(intf.byte_mask),      64'(0));
    chk("rst acks",      64'({intf.inst_ack, intf.data_ack}),     64'(0));
    chk("rst rdata",     64'({intf.inst_rdata, intf.data_rdata}), 64'(0));
    tick();

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Both ports at once: data first, then inst.
    do_reset();
    intf.inst_req = 1'b1; intf.inst_addr = 32'h8000_0010;
    intf.data_req = 1'b1; intf.data_we = 1'b0; intf.data_addr = 32'h104; intf.data_mask = 4'hF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("both read_op",    64'(intf.read_op),    64'(k == 1 || k == 4));
      chk("both data_ack",   64'(intf.data_ack),   64'(k == 3));
      chk("both inst_ack",   64'(intf.inst_ack),   64'(k == 6));
      chk("both inst_stall", 64'(intf.inst_stall), 64'(k < 6 && intf.inst_req));
      if (k >= 4 && k <= 6) chk("both bus_addr", 64'(intf.bus_addr), 64'(22'h10));
      if (k == 3) chk("both data_rdata", 64'(intf.data_rdata), 64'(32'h1122_BEEF));
      if (k == 6) chk("both inst_rdata", 64'(intf.inst_rdata), 64'(32'h2408_0001));
      tick();
      if (k == 3) intf.data_req = 1'b0;
      if (k == 6) intf.inst_req = 1'b0;
    end

    // Data keeps requesting: inst must be served between the two data accesses.
    do_reset();
    intf.inst_req = 1'b1; intf.data_req = 1'b1;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      chk("alt read_op",  64'(intf.read_op),  64'(k == 1 || k == 4 || k == 7));
      chk("alt data_ack", 64'(intf.data_ack), 64'(k == 3 || k == 9));
      chk("alt inst_ack", 64'(intf.inst_ack), 64'(k == 6));
      tick();
      if (k == 6) intf.inst_req = 1'b0;
      if (k == 9) intf.data_req = 1'b0;
    end

    // Reset during WAIT abandons the write with no ack.
    do_reset();
    intf.data_req = 1'b1; intf.data_we = 1'b1; intf.data_addr = 32'h300;
    intf.data_wdata = 32'h1234_5678; intf.data_mask = 4'hF;
    @(negedge clk); tick();
    @(negedge clk);
    chk("rstw write_op c1", 64'(intf.write_op), 64'(1));
    tick();
    rst = 1'b1; intf.data_req = 1'b0;
    @(negedge clk);
    chk("rstw c2 ops/ack", 64'({intf.read_op, intf.write_op, intf.data_ack}), 64'(0));
    tick();
    @(negedge clk);
    chk("rstw c3 ops",      64'({intf.read_op, intf.write_op}),  64'(0));
    chk("rstw c3 acks",     64'({intf.inst_ack, intf.data_ack}), 64'(0));
    chk("rstw c3 bus_addr", 64'(intf.bus_addr),       64'(0));
    chk("rstw c3 mask",     64'(intf.byte_mask),      64'(0));
    chk("rstw c3 wdata",    64'(intf.bus_data_write), 64'(0));
    chk("rstw c3 rdata",    64'(intf.data_rdata),     64'(0));
    tick();
    rst = 1'b0;
    run_vec(vecs[0], 10);

    // Reset while read_op is high.
    intf.inst_req = 1'b1; intf.inst_addr = 32'h10;
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rstr read_op c1", 64'(intf.read_op), 64'(1));
    tick();
    rst = 1'b0; intf.inst_req = 1'b0;
    @(negedge clk);
    chk("rstr read_op c2", 64'(intf.read_op), 64'(0));
    tick();
    @(negedge clk);
    chk("rstr inst_ack c3", 64'(intf.inst_ack), 64'(0));
    tick();

    // Address change mid-grant has no effect.
    intf.data_req = 1'b1; intf.data_we = 1'b0; intf.data_addr = 32'h100; intf.data_mask = 4'hF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k >= 1) chk("chg bus_addr", 64'(intf.bus_addr), 64'(22'h100));
      chk("chg data_ack", 64'(intf.data_ack), 64'(k == 3));
      if (k == 3) chk("chg data_rdata", 64'(intf.data_rdata), 64'(32'h55AA_55AA));
      tick();
      if (k == 1) intf.data_addr = 32'h200;
    end
    intf.data_req = 1'b0;
    tick();

    // Randomized traffic against the reference model.
    seed = $urandom | 32'd1;
    mem_clr = 1'b1;
    tick();
    mem_clr = 1'b0;
    ref_wr = '0;
    do_reset();
    infl = 1'b0; lwd = 1'b0; g_data = 1'b0; g_we = 1'b0;
    g_addr = '0; g_wdata = '0; g_mask = '0;
    ack_c = -10; next_free = 0;
    i_busy = 1'b0; d_busy = 1'b0; last_iack = 1'b0; last_dack = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (last_iack) begin i_busy = 1'b0; intf.inst_req = 1'b0; end
      if (last_dack) begin d_busy = 1'b0; intf.data_req = 1'b0; end
      if (!i_busy && $urandom_range(2) == 0) begin
        i_busy = 1'b1; intf.inst_req = 1'b1; intf.inst_addr = $urandom;
      end else if (i_busy && $urandom_range(7) == 0) begin
        intf.inst_addr = $urandom;
      end
      if (!d_busy && $urandom_range(2) == 0) begin
        d_busy = 1'b1; intf.data_req = 1'b1; intf.data_we = 1'($urandom_range(1));
        intf.data_addr = $urandom; intf.data_wdata = $urandom;
        intf.data_mask = 4'($urandom_range(15));
      end else if (d_busy && $urandom_range(7) == 0) begin
        intf.data_addr = $urandom; intf.data_wdata = $urandom;
      end

      @(negedge clk);
      acked = infl && (c == ack_c);
      chk("rnd inst_ack", 64'(intf.inst_ack), 64'(acked && !g_data));
      chk("rnd data_ack", 64'(intf.data_ack), 64'(acked && g_data));
      chk("rnd read_op",  64'(intf.read_op),  64'(infl && c == ack_c - 2 && !g_we));
      chk("rnd write_op", 64'(intf.write_op), 64'(infl && c == ack_c - 2 && g_we));
      chk("rnd inst_stall", 64'(intf.inst_stall), 64'(intf.inst_req && !(acked && !g_data)));
      chk("rnd data_stall", 64'(intf.data_stall), 64'(intf.data_req && !(acked && g_data)));
      if (infl && c >= ack_c - 2) begin
        chk("rnd bus_addr",  64'(intf.bus_addr),  64'(g_addr[21:0]));
        chk("rnd byte_mask", 64'(intf.byte_mask), 64'(g_mask));
        if (g_we) chk("rnd bus_wdata", 64'(intf.bus_data_write), 64'(g_wdata));
      end
      if (acked) begin
        idx = g_addr[9:2];
        cur = ref_wr[idx] ? ref_mem[idx] : base_val(idx, seed);
        if (g_we) begin
          ref_mem[idx] = merge(cur, g_wdata, g_mask);
          ref_wr[idx]  = 1'b1;
        end else if (g_data) begin
          chk("rnd data_rdata", 64'(intf.data_rdata), 64'(cur));
        end else begin
          chk("rnd inst_rdata", 64'(intf.inst_rdata), 64'(cur));
        end
        infl = 1'b0;
      end
      if (c >= next_free) begin
        ci = intf.inst_req && !(acked && !g_data);
        cd = intf.data_req && !(acked && g_data);
        if (ci || cd) begin
          win = cd && (!ci || !lwd);
          lwd = win; g_data = win;
          if (win) begin
            g_addr = intf.data_addr; g_we = intf.data_we;
            g_wdata = intf.data_wdata; g_mask = intf.data_mask;
          end else begin
            g_addr = intf.inst_addr; g_we = 1'b0; g_wdata = '0; g_mask = 4'hF;
          end
          infl = 1'b1; ack_c = c + 3; next_free = c + 3;
        end else begin
          next_free = c + 1;
        end
      end
      last_iack = intf.inst_ack;
      last_dack = intf.data_ack;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
